// File: rtl/snl_pkg.sv
// rtl/snl_pkg.sv - shared snakes-and-ladders types and constants
// Used by the turn scheduler, dice generator and board datapath.
package snl_pkg;

  typedef enum logic [2:0] {
    WAIT_ROLL = 3'd0,
    DICE      = 3'd1,
    MOVE      = 3'd2,
    MOVE_WAIT = 3'd3,
    NEXT      = 3'd4,
    GAME_OVER = 3'd5
  } state_e;

  localparam logic [2:0] DICE_MIN  = 3'd1;
  localparam logic [2:0] DICE_MAX  = 3'd6;
  localparam int         MAX_SIXES = 3;

endpackage

// File: rtl/roll_edge_sync.sv
// rtl/roll_edge_sync.sv - roll button synchroniser with registered rising-edge pulse
// Pulse appears three clocks after the input edge.
module roll_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - turn sequencing FSM for the snakes-and-ladders board
// Optional bonus turn on a six is enabled by defining EXTRA_TURN_ON_SIX_EN.
module turn_scheduler
  import snl_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             roll,
  output logic             dice_req,
  input  logic             dice_valid,
  input  logic [2:0]       dice_value,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [PID_W-1:0] mv_player,
  output logic [2:0]       mv_steps,
  input  logic             mv_done,
  input  logic             mv_win,
  output logic [PID_W-1:0] cur_player,
  output logic             busy,
  output logic             game_over,
  output logic [PID_W-1:0] winner,
  output logic [CNT_W-1:0] turn_count
);

  state_e             state_q, state_d;
  logic [PID_W-1:0]   cur_player_q, cur_player_d;
  logic [PID_W-1:0]   winner_q, winner_d;
  logic [2:0]         steps_q, steps_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_inc;
  logic [PID_W-1:0]   next_player;
  logic               roll_pulse;

  roll_edge_sync u_roll_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (roll),
    .pulse_o (roll_pulse)
  );

  assign count_inc   = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
  assign next_player = (cur_player_q == PID_W'(NUM_PLAYERS - 1)) ? '0
                                                                  : cur_player_q + PID_W'(1);

`ifdef EXTRA_TURN_ON_SIX_EN
  logic [1:0] sixes_q, sixes_d;
`endif

  always_comb begin
    state_d      = state_q;
    cur_player_d = cur_player_q;
    winner_d     = winner_q;
    steps_d      = steps_q;
    count_d      = count_q;
`ifdef EXTRA_TURN_ON_SIX_EN
    sixes_d      = sixes_q;
`endif
    unique case (state_q)
      WAIT_ROLL: if (roll_pulse) state_d = DICE;
      // Out-of-range dice values are silently re-requested.
      DICE: begin
        if (dice_valid && dice_value >= DICE_MIN && dice_value <= DICE_MAX) begin
          steps_d = dice_value;
          state_d = MOVE;
        end
      end
      MOVE: if (mv_ready) state_d = MOVE_WAIT;
      MOVE_WAIT: begin
        if (mv_done) begin
          if (mv_win) begin
            winner_d = cur_player_q;
            count_d  = count_inc;
            state_d  = GAME_OVER;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        count_d = count_inc;
        state_d = WAIT_ROLL;
`ifdef EXTRA_TURN_ON_SIX_EN
        // A six keeps the turn unless it is the last allowed consecutive six.
        if (steps_q == DICE_MAX && sixes_q < 2'(MAX_SIXES - 1)) begin
          sixes_d = sixes_q + 2'd1;
        end else begin
          sixes_d      = '0;
          cur_player_d = next_player;
        end
`else
        cur_player_d = next_player;
`endif
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = WAIT_ROLL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_ROLL;
      cur_player_q <= '0;
      winner_q     <= '0;
      steps_q      <= '0;
      count_q      <= '0;
`ifdef EXTRA_TURN_ON_SIX_EN
      sixes_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_player_q <= cur_player_d;
      winner_q     <= winner_d;
      steps_q      <= steps_d;
      count_q      <= count_d;
`ifdef EXTRA_TURN_ON_SIX_EN
      sixes_q      <= sixes_d;
`endif
    end
  end

  assign dice_req   = (state_q == DICE);
  assign mv_valid   = (state_q == MOVE);
  assign mv_player  = cur_player_q;
  assign mv_steps   = steps_q;
  assign cur_player = cur_player_q;
  assign busy       = (state_q != WAIT_ROLL) && (state_q != GAME_OVER);
  assign game_over  = (state_q == GAME_OVER);
  assign winner     = winner_q;
  assign turn_count = count_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - directed scoreboard bench for turn_scheduler
module tb_turn_scheduler;

  localparam int NP = 2;
  localparam int PW = 1;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          roll;
  logic          dice_req;
  logic          dice_valid;
  logic [2:0]    dice_value;
  logic          mv_valid;
  logic          mv_ready;
  logic [PW-1:0] mv_player;
  logic [2:0]    mv_steps;
  logic          mv_done;
  logic          mv_win;
  logic [PW-1:0] cur_player;
  logic          busy;
  logic          game_over;
  logic [PW-1:0] winner;
  logic [CW-1:0] turn_count;

  turn_scheduler #(.NUM_PLAYERS(NP), .PID_W(PW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .roll       (roll),
    .dice_req   (dice_req),
    .dice_valid (dice_valid),
    .dice_value (dice_value),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .mv_player  (mv_player),
    .mv_steps   (mv_steps),
    .mv_done    (mv_done),
    .mv_win     (mv_win),
    .cur_player (cur_player),
    .busy       (busy),
    .game_over  (game_over),
    .winner     (winner),
    .turn_count (turn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] player;
    logic [2:0]    steps;
  } mv_t;

  mv_t           exp_q[$];
  int            total = 0;
  int            bad   = 0;
  logic [PW-1:0] m_player = '0;
  logic [CW-1:0] m_count  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    roll = 1'b1;
    tick(6);
    roll = 1'b0;
    tick(2);
  endtask

  task automatic give_dice(input logic [2:0] v, input bit push, input logic [PW-1:0] p);
    int n = 0;
    while (!dice_req && n < 50) begin
      tick(1);
      n++;
    end
    chk("dice_req_seen", 32'(dice_req), 32'd1);
    if (push) exp_q.push_back('{player: p, steps: v});
    dice_valid = 1'b1;
    dice_value = v;
    tick(1);
    dice_valid = 1'b0;
    dice_value = 3'd0;
  endtask

  task automatic do_move(input logic win, input int ready_delay);
    int  n = 0;
    mv_t e;
    while (!mv_valid && n < 50) begin
      tick(1);
      n++;
    end
    chk("mv_valid_seen", 32'(mv_valid), 32'd1);
    chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("mv_player", 32'(mv_player), 32'(e.player));
    chk("mv_steps", 32'(mv_steps), 32'(e.steps));
    repeat (ready_delay) begin
      tick(1);
      chk("mv_hold", {mv_valid, mv_player, mv_steps}, {1'b1, e.player, e.steps});
    end
    mv_ready = 1'b1;
    tick(1);
    mv_ready = 1'b0;
    chk("mv_valid_drop", 32'(mv_valid), 32'd0);
    tick(2);
    mv_done = 1'b1;
    mv_win  = win;
    tick(1);
    mv_done = 1'b0;
    mv_win  = 1'b0;
    tick(2);
  endtask

  function automatic logic [PW-1:0] rot(input logic [PW-1:0] p);
    return (int'(p) == NP - 1) ? '0 : p + 1'b1;
  endfunction

  initial begin
    reset = 1'b0; roll = 1'b0; dice_valid = 1'b0; dice_value = 3'd0;
    mv_ready = 1'b0; mv_done = 1'b0; mv_win = 1'b0;
    tick(3);
    chk("rst_outputs", {dice_req, mv_valid, busy, game_over, cur_player, turn_count}, '0);
    reset = 1'b1;
    tick(50);
    chk("idle_outputs", {dice_req, mv_valid, busy, game_over, cur_player, turn_count}, '0);

    // Basic turn: player 0 rolls 4, ready after 3 cycles.
    press();
    give_dice(3'd4, 1'b1, m_player);
    do_move(1'b0, 3);
    m_player = rot(m_player); m_count++;
    chk("t2_cur_player", 32'(cur_player), 32'(m_player));
    chk("t2_turn_count", 32'(turn_count), 32'(m_count));

    // Illegal dice values are re-requested.
    press();
    give_dice(3'd0, 1'b0, m_player);
    chk("t3_req_after_0", 32'(dice_req), 32'd1);
    give_dice(3'd7, 1'b0, m_player);
    chk("t3_req_after_7", 32'(dice_req), 32'd1);
    give_dice(3'd2, 1'b1, m_player);
    do_move(1'b0, 1);
    m_player = rot(m_player); m_count++;
    chk("t3_cur_player", 32'(cur_player), 32'(m_player));
    chk("t3_turn_count", 32'(turn_count), 32'(m_count));

    // Stray dice_valid in WAIT_ROLL, and presses while busy.
    dice_valid = 1'b1; dice_value = 3'd3;
    tick(1);
    dice_valid = 1'b0; dice_value = 3'd0;
    tick(3);
    chk("t4_idle_dice", 32'(busy), 32'd0);
    press();
    press();
    give_dice(3'd5, 1'b1, m_player);
    press();
    do_move(1'b0, 1);
    m_player = rot(m_player); m_count++;
    tick(10);
    chk("t4_no_queue", {busy, dice_req, mv_valid}, 3'b000);
    chk("t4_turn_count", 32'(turn_count), 32'(m_count));
    chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Bring turn back to player 0, then three sixes.
    while (m_player != '0) begin
      press();
      give_dice(3'd3, 1'b1, m_player);
      do_move(1'b0, 0);
      m_player = rot(m_player); m_count++;
    end
    for (int i = 0; i < 3; i++) begin
      press();
      give_dice(3'd6, 1'b1, m_player);
      do_move(1'b0, 0);
      m_count++;
`ifdef EXTRA_TURN_ON_SIX_EN
      if (i == 2) m_player = rot(m_player);
`else
      m_player = rot(m_player);
`endif
      chk("t6_cur_player", 32'(cur_player), 32'(m_player));
      chk("t6_turn_count", 32'(turn_count), 32'(m_count));
    end

    // Winning move by player 1.
    if (m_player != 1'b1) begin
      press();
      give_dice(3'd1, 1'b1, m_player);
      do_move(1'b0, 0);
      m_player = rot(m_player); m_count++;
    end
    press();
    give_dice(3'd3, 1'b1, m_player);
    do_move(1'b1, 2);
    m_count++;
    chk("t5_game_over", 32'(game_over), 32'd1);
    chk("t5_winner", 32'(winner), 32'd1);
    chk("t5_turn_count", 32'(turn_count), 32'(m_count));
    press();
    tick(10);
    chk("t5_frozen", {dice_req, mv_valid, busy, game_over}, 4'b0001);
    chk("t5_count_frozen", 32'(turn_count), 32'(m_count));

    // Asynchronous reset mid-turn drops the dice request immediately.
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    press();
    chk("rst_mid_req", 32'(dice_req), 32'd1);
    #1 reset = 1'b0;
    #1 chk("rst_async_drop", {dice_req, game_over, turn_count}, '0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
